// File: rtl/register_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : register_operand_stage_if
// Description : Instruction handshake, ALU operand/result bus, retire and
//               debug-read signals of the register operand stage.
//               master : instruction source / ALU / debug side
//               slave  : register_operand_stage
// Revision    : 1.0 - initial release
// ============================================================================
interface register_operand_stage_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_word;
    logic [2:0]  alu_subfunction_3;
    logic [6:0]  alu_subfunction_7;
    logic [31:0] alu_register1_value;
    logic [31:0] alu_register2_value;
    logic [31:0] alu_result;
    logic        alu_decoding_error;
    logic        retire_valid;
    logic [4:0]  retire_rd;
    logic        halted;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    modport master (
        output instr_valid, instr_word, alu_result, alu_decoding_error, dbg_addr,
        input  instr_ready, alu_subfunction_3, alu_subfunction_7,
               alu_register1_value, alu_register2_value,
               retire_valid, retire_rd, halted, dbg_data
    );

    modport slave (
        input  instr_valid, instr_word, alu_result, alu_decoding_error, dbg_addr,
        output instr_ready, alu_subfunction_3, alu_subfunction_7,
               alu_register1_value, alu_register2_value,
               retire_valid, retire_rd, halted, dbg_data
    );
endinterface
`default_nettype wire

// File: rtl/register_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : register_operand_stage
// Description : Non-pipelined sequencer plus integer register file feeding an
//               R-type ALU. Accepts one instruction in IDLE, latches rs1/rs2
//               values and funct3/funct7 for the ALU, waits for the registered
//               ALU result, then writes rd. Any decode error halts the stage
//               until reset.
// Ports       : clk   - rising-edge clock
//               reset - synchronous, active-high
//               bus   - register_operand_stage_if.slave (handshake, ALU
//                       operands/result, retire, halted, debug read)
// Revision    : 1.0 - initial release
// ============================================================================
module register_operand_stage #(
    parameter int REG_COUNT       = 32,
    parameter bit RESET_CLEARS_RF = 1'b1
) (
    input  wire logic               clk,
    input  wire logic               reset,
    register_operand_stage_if.slave bus
);

    localparam int         c_IDX_W    = $clog2(REG_COUNT);
    localparam logic [6:0] c_OPCODE_R = 7'b0110011;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WRITEBACK = 2'd2,
        S_HALT      = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_accept;
    logic   w_wb_ok;
    logic   w_is_r;

    logic [31:0] r_rf [REG_COUNT];
    logic [4:0]  r_rd;
    logic [2:0]  r_funct3;
    logic [6:0]  r_funct7;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic        r_retire_valid;
    logic [4:0]  r_retire_rd;

    logic [c_IDX_W-1:0] w_rs1_idx;
    logic [c_IDX_W-1:0] w_rs2_idx;
    logic [c_IDX_W-1:0] w_dbg_idx;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic [31:0]        w_rs1_val;
    logic [31:0]        w_rs2_val;

    assign w_is_r    = (bus.instr_word[6:0] == c_OPCODE_R);
    assign w_rs1_idx = bus.instr_word[15 +: c_IDX_W];
    assign w_rs2_idx = bus.instr_word[20 +: c_IDX_W];
    assign w_dbg_idx = bus.dbg_addr[c_IDX_W-1:0];
    assign w_rd_idx  = r_rd[c_IDX_W-1:0];

    // x0 is hardwired to zero on every read port; its storage is never written.
    assign w_rs1_val = (w_rs1_idx == '0) ? 32'd0 : r_rf[w_rs1_idx];
    assign w_rs2_val = (w_rs2_idx == '0) ? 32'd0 : r_rf[w_rs2_idx];

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_wb_ok      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = w_is_r ? S_ISSUE : S_HALT;
                end
            end
            S_ISSUE:     w_state_next = S_WRITEBACK;
            S_WRITEBACK: begin
                // The ALU error flag is only meaningful here; elsewhere it is ignored.
                if (bus.alu_decoding_error) begin
                    w_state_next = S_HALT;
                end else begin
                    w_wb_ok      = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default:     w_state_next = S_HALT;
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand / subfunction latches; held until the next accepted R-type.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd     <= '0;
            r_funct3 <= '0;
            r_funct7 <= '0;
            r_op1    <= '0;
            r_op2    <= '0;
        end else if (w_accept && w_is_r) begin
            r_rd     <= bus.instr_word[11:7];
            r_funct3 <= bus.instr_word[14:12];
            r_funct7 <= bus.instr_word[31:25];
            r_op1    <= w_rs1_val;
            r_op2    <= w_rs2_val;
        end
    end

    // Retire pulse marks the edge on which rd was written, so it is visible
    // in the cycle after WRITEBACK and can never be high two cycles running.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retire_valid <= 1'b0;
            r_retire_rd    <= '0;
        end else begin
            r_retire_valid <= w_wb_ok;
            if (w_wb_ok) begin
                r_retire_rd <= r_rd;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Register file. Reset wins over a coincident writeback, so an in-flight
    // instruction never commits across reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            if (RESET_CLEARS_RF) begin
                for (int i = 0; i < REG_COUNT; i++) begin
                    r_rf[i] <= '0;
                end
            end
        end else if (w_wb_ok && (w_rd_idx != '0)) begin
            r_rf[w_rd_idx] <= bus.alu_result;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.instr_ready         = (r_state == S_IDLE);
    assign bus.halted              = (r_state == S_HALT);
    assign bus.alu_subfunction_3   = r_funct3;
    assign bus.alu_subfunction_7   = r_funct7;
    assign bus.alu_register1_value = r_op1;
    assign bus.alu_register2_value = r_op2;
    assign bus.retire_valid        = r_retire_valid;
    assign bus.retire_rd           = r_retire_rd;
    assign bus.dbg_data            = (w_dbg_idx == '0) ? 32'd0 : r_rf[w_dbg_idx];

endmodule
`default_nettype wire

// File: tb/tb_register_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_operand_stage
// Description : Directed self-checking bench for register_operand_stage with a
//               small registered ADD/SUB ALU model whose result can be
//               overridden to seed register values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_operand_stage;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic        force_en;
    logic [31:0] force_val;

    register_operand_stage_if bus ();

    register_operand_stage #(
        .REG_COUNT       (32),
        .RESET_CLEARS_RF (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Registered ALU model: samples operands on every edge, result one cycle later.
    always @(posedge clk) begin
        if (force_en)
            bus.alu_result <= force_val;
        else if (bus.alu_subfunction_7 == 7'h20)
            bus.alu_result <= bus.alu_register1_value - bus.alu_register2_value;
        else
            bus.alu_result <= bus.alu_register1_value + bus.alu_register2_value;
        bus.alu_decoding_error <= !((bus.alu_subfunction_7 == 7'h00) || (bus.alu_subfunction_7 == 7'h20))
                                  || (bus.alu_subfunction_3 != 3'd0);
    end

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_read(input logic [4:0] a, output logic [31:0] d);
        bus.dbg_addr = a;
        #1;
        d = bus.dbg_data;
    endtask

    // One full instruction: accept (E0), ALU capture (E1), writeback (E2).
    task automatic do_instr(input logic [31:0] w, input logic fen, input logic [31:0] fval,
                            input logic [31:0] e1, input logic [31:0] e2,
                            input logic [4:0] erd, input logic [31:0] eres);
        logic [31:0] d;
        logic [2:0]  f3;
        logic [6:0]  f7;
        f3 = w[14:12];
        f7 = w[31:25];
        bus.instr_word  = w;
        bus.instr_valid = 1'b1;
        force_en        = fen;
        force_val       = fval;
        step();
        bus.instr_valid = 1'b0;
        total++;
        if (bus.instr_ready !== 1'b0 || bus.alu_register1_value !== e1 || bus.alu_register2_value !== e2
            || bus.alu_subfunction_3 !== f3 || bus.alu_subfunction_7 !== f7) begin
            bad++;
            $display("FAIL issue_ops w=%h: ready=%b op1=%0d op2=%0d f3=%h f7=%h, want ready=0 op1=%0d op2=%0d f3=%h f7=%h",
                     w, bus.instr_ready, bus.alu_register1_value, bus.alu_register2_value,
                     bus.alu_subfunction_3, bus.alu_subfunction_7, e1, e2, f3, f7);
        end
        step();
        total++;
        if (bus.retire_valid !== 1'b0) begin
            bad++;
            $display("FAIL early_retire w=%h: retire_valid=%b want 0", w, bus.retire_valid);
        end
        step();
        force_en = 1'b0;
        total++;
        if (bus.retire_valid !== 1'b1 || bus.retire_rd !== erd || bus.instr_ready !== 1'b1) begin
            bad++;
            $display("FAIL retire w=%h: valid=%b rd=%0d ready=%b, want valid=1 rd=%0d ready=1",
                     w, bus.retire_valid, bus.retire_rd, bus.instr_ready, erd);
        end
        dbg_read(erd, d);
        total++;
        if (d !== eres) begin
            bad++;
            $display("FAIL rd_value x%0d: got %0d want %0d", erd, d, eres);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        apply_reset();
        total++;
        if (bus.instr_ready !== 1'b1 || bus.halted !== 1'b0 || bus.retire_valid !== 1'b0 || bus.retire_rd !== 5'd0
            || bus.alu_register1_value !== 32'd0 || bus.alu_register2_value !== 32'd0
            || bus.alu_subfunction_3 !== 3'd0 || bus.alu_subfunction_7 !== 7'd0) begin
            bad++;
            $display("FAIL reset_state: ready=%b halted=%b rv=%b rd=%0d op1=%h op2=%h f3=%h f7=%h, want 1 0 0 0 and zero ALU outputs",
                     bus.instr_ready, bus.halted, bus.retire_valid, bus.retire_rd, bus.alu_register1_value,
                     bus.alu_register2_value, bus.alu_subfunction_3, bus.alu_subfunction_7);
        end
        for (int i = 1; i < 32; i += 10) begin
            dbg_read(5'(i), d);
            total++;
            if (d !== 32'd0) begin
                bad++;
                $display("FAIL reset_rf x%0d: got %h want 0", i, d);
            end
        end
    endtask

    task automatic test_add();
        do_instr(r_type(7'h00, 5'd0, 5'd0, 3'd0, 5'd1), 1'b1, 32'd5, 32'd0, 32'd0, 5'd1, 32'd5);
        do_instr(r_type(7'h00, 5'd0, 5'd0, 3'd0, 5'd2), 1'b1, 32'd7, 32'd0, 32'd0, 5'd2, 32'd7);
        do_instr(32'h002081B3, 1'b0, 32'd0, 32'd5, 32'd7, 5'd3, 32'd12);
    endtask

    task automatic test_x0_write();
        do_instr(r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 1'b0, 32'd0, 32'd5, 32'd7, 5'd0, 32'd0);
    endtask

    task automatic test_sub();
        do_instr(r_type(7'h20, 5'd1, 5'd2, 3'd0, 5'd7), 1'b0, 32'd0, 32'd7, 32'd5, 5'd7, 32'd2);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        bus.instr_word  = r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd5);
        bus.instr_valid = 1'b1;
        step();                                            // E0: first accept
        bus.instr_word = r_type(7'h00, 5'd5, 5'd5, 3'd0, 5'd6);
        step();                                            // E1
        total++;
        if (bus.instr_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_busy: ready=%b want 0", bus.instr_ready);
        end
        step();                                            // E2: x5 written
        total++;
        if (bus.instr_ready !== 1'b1 || bus.retire_valid !== 1'b1 || bus.retire_rd !== 5'd5) begin
            bad++;
            $display("FAIL b2b_first_retire: ready=%b rv=%b rd=%0d want 1 1 5",
                     bus.instr_ready, bus.retire_valid, bus.retire_rd);
        end
        step();                                            // E3: second accept
        bus.instr_valid = 1'b0;
        total++;
        if (bus.alu_register1_value !== 32'd12 || bus.alu_register2_value !== 32'd12 || bus.retire_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second_ops: op1=%0d op2=%0d rv=%b want 12 12 0",
                     bus.alu_register1_value, bus.alu_register2_value, bus.retire_valid);
        end
        step();
        step();
        dbg_read(5'd6, d);
        total++;
        if (bus.retire_valid !== 1'b1 || bus.retire_rd !== 5'd6 || d !== 32'd24) begin
            bad++;
            $display("FAIL b2b_second_retire: rv=%b rd=%0d x6=%0d want 1 6 24", bus.retire_valid, bus.retire_rd, d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        for (int k = 1; k <= 2; k++) begin
            bus.instr_word  = r_type(7'h00, 5'd0, 5'd0, 3'd0, 5'd8);
            bus.instr_valid = 1'b1;
            force_en        = 1'b1;
            force_val       = 32'd33;
            step();                                        // accepted, now ISSUE
            bus.instr_valid = 1'b0;
            if (k == 2) step();                            // now WRITEBACK
            reset = 1'b1;
            step();
            reset    = 1'b0;
            force_en = 1'b0;
            dbg_read(5'd8, d);
            total++;
            if (bus.instr_ready !== 1'b1 || bus.halted !== 1'b0 || bus.retire_valid !== 1'b0 || d !== 32'd0) begin
                bad++;
                $display("FAIL reset_mid_%0d: ready=%b halted=%b rv=%b x8=%0d want 1 0 0 0",
                         k, bus.instr_ready, bus.halted, bus.retire_valid, d);
            end
            dbg_read(5'd1, d);
            total++;
            if (d !== 32'd0) begin
                bad++;
                $display("FAIL reset_mid_clear_%0d: x1=%0d want 0", k, d);
            end
        end
    endtask

    task automatic test_bad_opcode();
        logic [31:0] d;
        do_instr(r_type(7'h00, 5'd0, 5'd0, 3'd0, 5'd1), 1'b1, 32'd5, 32'd0, 32'd0, 5'd1, 32'd5);
        bus.instr_word  = {12'd3, 5'd1, 3'd0, 5'd10, 7'b0010011};   // ADDI x10,x1,3
        bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
        total++;
        if (bus.halted !== 1'b1 || bus.instr_ready !== 1'b0) begin
            bad++;
            $display("FAIL itype_halt: halted=%b ready=%b want 1 0", bus.halted, bus.instr_ready);
        end
        step();
        step();
        dbg_read(5'd10, d);
        total++;
        if (bus.retire_valid !== 1'b0 || d !== 32'd0) begin
            bad++;
            $display("FAIL itype_no_write: rv=%b x10=%0d want 0 0", bus.retire_valid, d);
        end
        dbg_read(5'd1, d);
        total++;
        if (d !== 32'd5) begin
            bad++;
            $display("FAIL itype_rf_kept: x1=%0d want 5", d);
        end
    endtask

    task automatic test_alu_error();
        logic [31:0] d;
        do_instr(r_type(7'h00, 5'd0, 5'd0, 3'd0, 5'd1),  1'b1, 32'd5, 32'd0, 32'd0, 5'd1,  32'd5);
        do_instr(r_type(7'h00, 5'd0, 5'd0, 3'd0, 5'd2),  1'b1, 32'd7, 32'd0, 32'd0, 5'd2,  32'd7);
        do_instr(r_type(7'h00, 5'd0, 5'd0, 3'd0, 5'd11), 1'b1, 32'd9, 32'd0, 32'd0, 5'd11, 32'd9);
        bus.instr_word  = r_type(7'h01, 5'd2, 5'd1, 3'd0, 5'd11);   // MUL x11,x1,x2
        bus.instr_valid = 1'b1;
        step();                                            // E0
        bus.instr_valid = 1'b0;
        step();                                            // E1, WRITEBACK
        total++;
        if (bus.halted !== 1'b0) begin
            bad++;
            $display("FAIL err_early_halt: halted=%b want 0", bus.halted);
        end
        step();                                            // E2
        total++;
        if (bus.halted !== 1'b1 || bus.retire_valid !== 1'b0 || bus.instr_ready !== 1'b0) begin
            bad++;
            $display("FAIL err_halt: halted=%b rv=%b ready=%b want 1 0 0", bus.halted, bus.retire_valid, bus.instr_ready);
        end
        bus.instr_word  = 32'h002081B3;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (bus.halted !== 1'b1 || bus.instr_ready !== 1'b0 || bus.retire_valid !== 1'b0) begin
                bad++;
                $display("FAIL err_stay_halted cyc%0d: halted=%b ready=%b rv=%b want 1 0 0",
                         i, bus.halted, bus.instr_ready, bus.retire_valid);
            end
        end
        bus.instr_valid = 1'b0;
        dbg_read(5'd11, d);
        total++;
        if (d !== 32'd9) begin
            bad++;
            $display("FAIL err_rd_kept: x11=%0d want 9", d);
        end
    endtask

    initial begin
        reset           = 1'b1;
        force_en        = 1'b0;
        force_val       = 32'd0;
        bus.instr_valid = 1'b0;
        bus.instr_word  = 32'd0;
        bus.dbg_addr    = 5'd0;
        test_reset();
        test_add();
        test_x0_write();
        test_sub();
        test_back_to_back();
        test_reset_mid();
        test_bad_opcode();
        apply_reset();
        test_alu_error();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
